pipe_sel_mux: RTL and testbench

// - Parametrised N-input, W-bit select mux followed by a DEPTH-stage pipeline

---
 rtl/pipe_sel_mux.sv | 68 ++++++
 tb/tb_pipe_sel_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_mux.sv
// N-input, W-bit select mux feeding a DEPTH-stage pipeline with valid tracking.
// Supports stall (hold), flush (bubble insert) and a sticky illegal-select flag.
module pipe_sel_mux #(
   parameter  int W     = 32,
   parameter  int N     = 3,
   parameter  int DEPTH = 1,
   localparam int SELW  = (N <= 2) ? 1 : $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in_bus,
   input  logic [SELW-1:0]   sel,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic              sel_err
);

   logic [W-1:0] mux_data;
   logic         sel_legal;

   logic [W-1:0] stage_data  [DEPTH];
   logic         stage_valid [DEPTH];

   // Matching sel against each legal index makes codes >= N fall through to zero.
   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      mux_data  = '0;
      sel_legal = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (int'(sel) == k) begin
            sel_legal = 1'b1;
            if (in_valid) mux_data = in_bus[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            stage_data[i]  <= '0;
            stage_valid[i] <= 1'b0;
         end
         sel_err <= 1'b0;
      end else if (flush) begin
         // Flush wins over stall and leaves sel_err untouched.
         for (int i = 0; i < DEPTH; i++) begin
            stage_data[i]  <= '0;
            stage_valid[i] <= 1'b0;
         end
      end else if (!stall) begin
         stage_data[0]  <= mux_data;
         stage_valid[0] <= in_valid & sel_legal;
         for (int i = 1; i < DEPTH; i++) begin
            stage_data[i]  <= stage_data[i-1];
            stage_valid[i] <= stage_valid[i-1];
         end
         if (in_valid && !sel_legal) sel_err <= 1'b1;
      end
   end

   assign out_data  = stage_data[DEPTH-1];
   assign out_valid = stage_valid[DEPTH-1];

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: a W=32/N=3/DEPTH=2 instance driven by directed steps and a
// W=5/N=2/DEPTH=1 instance driven randomly, both compared against delay-line queue models.
module tb_pipe_sel_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [95:0] a_bus;
   logic [1:0]  a_sel;
   logic        a_valid, a_stall, a_flush;
   logic [31:0] a_data;
   logic        a_ovalid, a_err;

   logic [9:0]  b_bus;
   logic [0:0]  b_sel;
   logic        b_valid, b_stall, b_flush;
   logic [4:0]  b_data;
   logic        b_ovalid, b_err;

   pipe_sel_mux #(.W(32), .N(3), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .in_bus(a_bus), .sel(a_sel), .in_valid(a_valid),
      .stall(a_stall), .flush(a_flush), .out_data(a_data), .out_valid(a_ovalid),
      .sel_err(a_err)
   );

   pipe_sel_mux #(.W(5), .N(2), .DEPTH(1)) dut_b (
      .clk(clk), .rst(rst), .in_bus(b_bus), .sel(b_sel), .in_valid(b_valid),
      .stall(b_stall), .flush(b_flush), .out_data(b_data), .out_valid(b_ovalid),
      .sel_err(b_err)
   );

   typedef struct {
      logic        v;
      logic [31:0] d;
   } slot_t;

   // Each model is a delay line: oldest entry (index 0) is what the output shows.
   slot_t qa[$];
   slot_t qb[$];
   logic  ea, eb;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] VAL_A = 32'h11111111;
   localparam logic [31:0] VAL_B = 32'h22222222;
   localparam logic [31:0] VAL_C = 32'h33333333;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void fill_bubbles(inout slot_t q[$], input int depth);
      q.delete();
      for (int i = 0; i < depth; i++) q.push_back('{v: 1'b0, d: 32'h0});
   endfunction

   // Apply one clock edge's worth of behaviour to both models.
   task automatic model_edge();
      slot_t s;
      if (rst) begin
         fill_bubbles(qa, 2);
         fill_bubbles(qb, 1);
         ea = 1'b0;
         eb = 1'b0;
         return;
      end
      if (a_flush) fill_bubbles(qa, 2);
      else if (!a_stall) begin
         s.v = a_valid && (a_sel < 2'd3);
         s.d = s.v ? a_bus[a_sel*32 +: 32] : 32'h0;
         if (a_valid && a_sel == 2'd3) ea = 1'b1;
         void'(qa.pop_front());
         qa.push_back(s);
      end
      if (b_flush) fill_bubbles(qb, 1);
      else if (!b_stall) begin
         s.v = b_valid;
         s.d = b_valid ? {27'h0, b_bus[b_sel*5 +: 5]} : 32'h0;
         void'(qb.pop_front());
         qb.push_back(s);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_a_data"},  a_data,   qa[0].d);
      check({tag, "_a_valid"}, {31'h0, a_ovalid}, {31'h0, qa[0].v});
      check({tag, "_a_err"},   {31'h0, a_err},    {31'h0, ea});
      check({tag, "_b_data"},  {27'h0, b_data},   qb[0].d);
      check({tag, "_b_valid"}, {31'h0, b_ovalid}, {31'h0, qb[0].v});
      check({tag, "_b_err"},   {31'h0, b_err},    32'h0);
   endtask

   // Randomise the N=2 instance, take one edge, update models, sample 1 ns later.
   task automatic tick(input string tag);
      b_bus   = 10'($urandom);
      b_sel   = 1'($urandom);
      b_valid = ($urandom_range(0, 7) != 0);
      b_stall = ($urandom_range(0, 9) == 0);
      b_flush = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive_a(input logic v, input logic [1:0] s, input logic st, input logic fl);
      a_valid = v;
      a_sel   = s;
      a_stall = st;
      a_flush = fl;
   endtask

   logic [31:0] x_val, y_val;

   initial begin
      rst   = 1'b1;
      a_bus = {$urandom, $urandom, $urandom};
      drive_a(1'b1, 2'($urandom), 1'($urandom), 1'($urandom));
      tick("rst0");
      a_bus = {$urandom, $urandom, $urandom};
      drive_a(1'b1, 2'($urandom), 1'($urandom), 1'($urandom));
      tick("rst1");
      check("rst_out_data", a_data, 32'h0);
      rst = 1'b0;

      // Legal selects in sequence; results emerge two edges after presentation.
      a_bus = {VAL_C, VAL_B, VAL_A};
      drive_a(1'b1, 2'd0, 1'b0, 1'b0); tick("abc0");
      check("abc0_bubble", {31'h0, a_ovalid}, 32'h0);
      drive_a(1'b1, 2'd1, 1'b0, 1'b0); tick("abc1");
      check("abc1_const", a_data, VAL_A);
      drive_a(1'b1, 2'd2, 1'b0, 1'b0); tick("abc2");
      check("abc2_const", a_data, VAL_B);
      drive_a(1'b0, 2'd0, 1'b0, 1'b0); tick("abc3");
      check("abc3_const", a_data, VAL_C);
      check("abc3_valid", {31'h0, a_ovalid}, 32'h1);

      // Illegal select: sticky flag, bubble output, survives flush, cleared by reset.
      drive_a(1'b1, 2'd3, 1'b0, 1'b0); tick("ill0");
      check("ill_err_set", {31'h0, a_err}, 32'h1);
      drive_a(1'b0, 2'd0, 1'b0, 1'b0); tick("ill1");
      check("ill_bubble", {31'h0, a_ovalid}, 32'h0);
      drive_a(1'b0, 2'd0, 1'b0, 1'b1); tick("ill_flush");
      check("ill_err_hold", {31'h0, a_err}, 32'h1);
      drive_a(1'b0, 2'd0, 1'b0, 1'b0);
      rst = 1'b1; tick("ill_rst");
      rst = 1'b0;
      check("ill_err_clr", {31'h0, a_err}, 32'h0);

      // Long stall with two ops in flight.
      x_val = $urandom;
      y_val = $urandom;
      a_bus = {32'($urandom), y_val, x_val};
      drive_a(1'b1, 2'd0, 1'b0, 1'b0); tick("stl_x");
      drive_a(1'b1, 2'd1, 1'b0, 1'b0); tick("stl_y");
      check("stl_x_out", a_data, x_val);
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1, 2'd2, 1'b1, 1'b0); tick("stl_hold");
         check("stl_frozen", a_data, x_val);
      end
      drive_a(1'b0, 2'd0, 1'b0, 1'b0); tick("stl_rel0");
      check("stl_y_out", a_data, y_val);
      tick("stl_rel1");
      check("stl_no_dup", {31'h0, a_ovalid}, 32'h0);

      // Flush and stall together: flush wins, in-flight ops never appear.
      a_bus = {$urandom, $urandom, $urandom};
      drive_a(1'b1, 2'd0, 1'b0, 1'b0); tick("fs0");
      drive_a(1'b1, 2'd2, 1'b0, 1'b0); tick("fs1");
      drive_a(1'b1, 2'd1, 1'b1, 1'b1); tick("fs_both");
      check("fs_out_valid", {31'h0, a_ovalid}, 32'h0);
      drive_a(1'b0, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick("fs_after");
         check("fs_gone", {31'h0, a_ovalid}, 32'h0);
      end

      // Random mix of everything, including occasional mid-flight reset.
      for (int i = 0; i < 500; i++) begin
         a_bus = {$urandom, $urandom, $urandom};
         drive_a(($urandom_range(0, 3) != 0), 2'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
         rst = ($urandom_range(0, 59) == 0);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
